// File: rtl/rptr_empty_sync.sv
// Read-side pointer and empty/level logic for an asynchronous FIFO.
// Synchronizes the Gray write pointer into rclk and derives empty, fill level and underflow.
module rptr_empty_sync #(
  parameter int ADDRSIZE = 4,
  parameter int AE_LEVEL = 2
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic                rinc,
  input  logic [ADDRSIZE:0]   rwptr,
  input  logic                runder_clr,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty,
  output logic                ralmost_empty,
  output logic [ADDRSIZE:0]   rlevel,
  output logic                runderflow
);

  localparam int PW = ADDRSIZE + 1;
  localparam logic [PW-1:0] AE_THRESH = PW'(AE_LEVEL);

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return (b >> 1) ^ b;
  endfunction

  function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
    logic [PW-1:0] b;
    b[PW-1] = g[PW-1];
    for (int i = PW - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  logic [PW-1:0] rq1_wptr;
  logic [PW-1:0] rq2_wptr;
  logic [PW-1:0] rbin;
  logic [PW-1:0] rbinnext;
  logic [PW-1:0] rgraynext;
  logic [PW-1:0] wsyncbin;
  logic [PW-1:0] levelnext;
  logic          pop;

  // Stage 0: two-flop synchronizer for the write pointer, nothing in between
  always_ff @(posedge rclk) begin
    if (rrst) begin
      rq1_wptr <= '0;
      rq2_wptr <= '0;
    end else begin
      rq1_wptr <= rwptr;
      rq2_wptr <= rq1_wptr;
    end
  end

  // Stage 1: next-state pointer arithmetic; a pop on empty is suppressed here
  always_comb begin
    pop       = rinc & ~rempty;
    rbinnext  = rbin + PW'(pop);
    rgraynext = bin2gray(rbinnext);
    wsyncbin  = gray2bin(rq2_wptr);
    levelnext = wsyncbin - rbinnext;
  end

  assign raddr = rbin[ADDRSIZE-1:0];

  // Stage 2: registered pointers and flags, all derived from the post-pop pointer
  always_ff @(posedge rclk) begin
    if (rrst) begin
      rbin          <= '0;
      rptr          <= '0;
      rempty        <= 1'b1;
      rlevel        <= '0;
      ralmost_empty <= 1'b1;
      runderflow    <= 1'b0;
    end else begin
      rbin          <= rbinnext;
      rptr          <= rgraynext;
      rempty        <= (rgraynext == rq2_wptr);
      rlevel        <= levelnext;
      ralmost_empty <= (levelnext <= AE_THRESH);
      if (rinc && rempty) begin
        runderflow <= 1'b1;
      end else if (runder_clr) begin
        runderflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_rptr_empty_sync.sv
// Scoreboard bench for rptr_empty_sync with ADDRSIZE=4, AE_LEVEL=2.
module tb_rptr_empty_sync;

  logic       rclk = 1'b0;
  logic       rrst = 1'b1;
  logic       rinc = 1'b0;
  logic [4:0] rwptr = '0;
  logic       runder_clr = 1'b0;
  logic [3:0] raddr;
  logic [4:0] rptr;
  logic       rempty;
  logic       ralmost_empty;
  logic [4:0] rlevel;
  logic       runderflow;

  int n_pass = 0;
  int n_total = 0;

  typedef struct packed {
    logic [4:0] rptr;
    logic [3:0] raddr;
    logic [4:0] rlevel;
    logic       rempty;
    logic       rae;
    logic       runder;
  } exp_t;

  exp_t sbq[$];

  rptr_empty_sync #(.ADDRSIZE(4), .AE_LEVEL(2)) dut (
    .rclk(rclk), .rrst(rrst), .rinc(rinc), .rwptr(rwptr), .runder_clr(runder_clr),
    .raddr(raddr), .rptr(rptr), .rempty(rempty), .ralmost_empty(ralmost_empty),
    .rlevel(rlevel), .runderflow(runderflow)
  );

  always #5 rclk = ~rclk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  function automatic logic [4:0] to_gray(input logic [4:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic tick();
    @(posedge rclk);
    #1;
  endtask

  task automatic apply_reset(input logic [4:0] wp);
    rrst = 1'b1; rinc = 1'b0; runder_clr = 1'b0; rwptr = wp;
    tick(); tick();
    rrst = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    apply_reset(5'b00111);
    n_total++; if (rempty !== 1'b1) $display("FAIL reset_rempty got=%0b exp=1", rempty); else n_pass++;
    n_total++; if (ralmost_empty !== 1'b1) $display("FAIL reset_rae got=%0b exp=1", ralmost_empty); else n_pass++;
    n_total++; if (rptr !== 5'd0) $display("FAIL reset_rptr got=%b exp=00000", rptr); else n_pass++;
    n_total++; if (raddr !== 4'd0) $display("FAIL reset_raddr got=%0d exp=0", raddr); else n_pass++;
    n_total++; if (rlevel !== 5'd0) $display("FAIL reset_rlevel got=%0d exp=0", rlevel); else n_pass++;
    n_total++; if (runderflow !== 1'b0) $display("FAIL reset_runder got=%0b exp=0", runderflow); else n_pass++;
    // write pointer (5 words) reaches the flags on the 3rd edge after release
    for (int k = 1; k <= 3; k++) begin
      e = '0; e.rempty = (k < 3); e.rlevel = (k < 3) ? 5'd0 : 5'd5;
      sbq.push_back(e);
    end
    for (int k = 1; k <= 3; k++) begin
      tick();
      e = sbq.pop_front();
      n_total++; if (rempty !== e.rempty) $display("FAIL reset_release_rempty edge=%0d got=%0b exp=%0b", k, rempty, e.rempty); else n_pass++;
      n_total++; if (rlevel !== e.rlevel) $display("FAIL reset_release_rlevel edge=%0d got=%0d exp=%0d", k, rlevel, e.rlevel); else n_pass++;
    end
  endtask

  task automatic test_drain();
    exp_t e;
    logic [4:0] rb;
    logic [4:0] wb;
    rb = 5'd0; wb = 5'd5;
    rinc = 1'b1;
    for (int i = 0; i < 5; i++) begin
      n_total++; if (raddr !== rb[3:0]) $display("FAIL drain_raddr pop=%0d got=%0d exp=%0d", i, raddr, rb[3:0]); else n_pass++;
      e = '0;
      e.rptr = to_gray(rb + 5'd1);
      e.rlevel = wb - (rb + 5'd1);
      e.rempty = ((rb + 5'd1) == wb);
      e.rae = (e.rlevel <= 5'd2);
      sbq.push_back(e);
      tick();
      rb = rb + 5'd1;
      e = sbq.pop_front();
      n_total++; if (rptr !== e.rptr) $display("FAIL drain_rptr pop=%0d got=%b exp=%b", i, rptr, e.rptr); else n_pass++;
      n_total++; if (rlevel !== e.rlevel) $display("FAIL drain_rlevel pop=%0d got=%0d exp=%0d", i, rlevel, e.rlevel); else n_pass++;
      n_total++; if (rempty !== e.rempty) $display("FAIL drain_rempty pop=%0d got=%0b exp=%0b", i, rempty, e.rempty); else n_pass++;
      n_total++; if (ralmost_empty !== e.rae) $display("FAIL drain_rae pop=%0d got=%0b exp=%0b", i, ralmost_empty, e.rae); else n_pass++;
    end
    rinc = 1'b0;
  endtask

  task automatic test_underflow();
    // sequence of {rinc, runder_clr} per edge and resulting sticky flag
    logic [1:0] stim [7];
    logic       expu [7];
    exp_t e;
    stim = '{2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b11, 2'b01};
    expu = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 7; i++) begin
      rinc = stim[i][1]; runder_clr = stim[i][0];
      e = '0; e.runder = expu[i]; e.raddr = 4'd5; e.rptr = 5'b00111; e.rempty = 1'b1;
      sbq.push_back(e);
      tick();
      e = sbq.pop_front();
      n_total++; if (runderflow !== e.runder) $display("FAIL underflow_flag step=%0d got=%0b exp=%0b", i, runderflow, e.runder); else n_pass++;
      n_total++; if (raddr !== e.raddr) $display("FAIL underflow_raddr step=%0d got=%0d exp=%0d", i, raddr, e.raddr); else n_pass++;
      n_total++; if (rptr !== e.rptr) $display("FAIL underflow_rptr step=%0d got=%b exp=%b", i, rptr, e.rptr); else n_pass++;
      n_total++; if (rempty !== e.rempty) $display("FAIL underflow_rempty step=%0d got=%0b exp=%0b", i, rempty, e.rempty); else n_pass++;
    end
    rinc = 1'b0; runder_clr = 1'b0;
  endtask

  task automatic test_single_word();
    exp_t e;
    apply_reset(5'b00000);
    tick(); tick(); tick();
    rwptr = 5'b00001;
    for (int k = 1; k <= 3; k++) begin
      e = '0; e.rempty = (k < 3); e.rlevel = (k < 3) ? 5'd0 : 5'd1; e.rae = 1'b1;
      sbq.push_back(e);
    end
    for (int k = 1; k <= 3; k++) begin
      tick();
      e = sbq.pop_front();
      n_total++; if (rempty !== e.rempty) $display("FAIL single_rempty edge=%0d got=%0b exp=%0b", k, rempty, e.rempty); else n_pass++;
      n_total++; if (rlevel !== e.rlevel) $display("FAIL single_rlevel edge=%0d got=%0d exp=%0d", k, rlevel, e.rlevel); else n_pass++;
      n_total++; if (ralmost_empty !== e.rae) $display("FAIL single_rae edge=%0d got=%0b exp=%0b", k, ralmost_empty, e.rae); else n_pass++;
    end
    rinc = 1'b1;
    tick();
    rinc = 1'b0;
    n_total++; if (rempty !== 1'b1) $display("FAIL single_pop_rempty got=%0b exp=1", rempty); else n_pass++;
    n_total++; if (rlevel !== 5'd0) $display("FAIL single_pop_rlevel got=%0d exp=0", rlevel); else n_pass++;
    n_total++; if (raddr !== 4'd1) $display("FAIL single_pop_raddr got=%0d exp=1", raddr); else n_pass++;
  endtask

  task automatic test_wrap_full();
    exp_t e;
    logic [4:0] rb;
    apply_reset(5'b11000);
    tick(); tick(); tick();
    n_total++; if (rlevel !== 5'b10000) $display("FAIL full_rlevel got=%b exp=10000", rlevel); else n_pass++;
    n_total++; if (rempty !== 1'b0) $display("FAIL full_rempty got=%0b exp=0", rempty); else n_pass++;
    n_total++; if (ralmost_empty !== 1'b0) $display("FAIL full_rae got=%0b exp=0", ralmost_empty); else n_pass++;
    rb = 5'd0;
    rinc = 1'b1;
    for (int i = 0; i < 16; i++) begin
      n_total++; if (raddr !== rb[3:0]) $display("FAIL wrap_raddr pop=%0d got=%0d exp=%0d", i, raddr, rb[3:0]); else n_pass++;
      e = '0; e.rlevel = 5'd16 - (rb + 5'd1); e.rempty = (i == 15); e.rptr = to_gray(rb + 5'd1);
      sbq.push_back(e);
      tick();
      rb = rb + 5'd1;
      e = sbq.pop_front();
      n_total++; if (rlevel !== e.rlevel) $display("FAIL wrap_rlevel pop=%0d got=%0d exp=%0d", i, rlevel, e.rlevel); else n_pass++;
      n_total++; if (rempty !== e.rempty) $display("FAIL wrap_rempty pop=%0d got=%0b exp=%0b", i, rempty, e.rempty); else n_pass++;
      n_total++; if (rptr !== e.rptr) $display("FAIL wrap_rptr pop=%0d got=%b exp=%b", i, rptr, e.rptr); else n_pass++;
    end
    rinc = 1'b0;
    n_total++; if (rptr !== 5'b11000) $display("FAIL wrap_end_rptr got=%b exp=11000", rptr); else n_pass++;
    n_total++; if (raddr !== 4'd0) $display("FAIL wrap_end_raddr got=%0d exp=0", raddr); else n_pass++;
    rwptr = 5'b11001;
    tick(); tick(); tick();
    n_total++; if (rlevel !== 5'd1) $display("FAIL wrap_after_rlevel got=%0d exp=1", rlevel); else n_pass++;
    n_total++; if (rempty !== 1'b0) $display("FAIL wrap_after_rempty got=%0b exp=0", rempty); else n_pass++;
  endtask

  task automatic test_reset_mid_drain();
    exp_t e;
    apply_reset(5'b00111);
    tick(); tick(); tick();
    rinc = 1'b1;
    tick(); tick();
    n_total++; if (rlevel !== 5'd3) $display("FAIL mid_pre_rlevel got=%0d exp=3", rlevel); else n_pass++;
    rrst = 1'b1; runder_clr = 1'b0;
    tick();
    n_total++; if (rptr !== 5'd0) $display("FAIL mid_rptr got=%b exp=00000", rptr); else n_pass++;
    n_total++; if (raddr !== 4'd0) $display("FAIL mid_raddr got=%0d exp=0", raddr); else n_pass++;
    n_total++; if (rlevel !== 5'd0) $display("FAIL mid_rlevel got=%0d exp=0", rlevel); else n_pass++;
    n_total++; if (rempty !== 1'b1) $display("FAIL mid_rempty got=%0b exp=1", rempty); else n_pass++;
    n_total++; if (ralmost_empty !== 1'b1) $display("FAIL mid_rae got=%0b exp=1", ralmost_empty); else n_pass++;
    n_total++; if (runderflow !== 1'b0) $display("FAIL mid_runder got=%0b exp=0", runderflow); else n_pass++;
    rrst = 1'b0; rinc = 1'b0;
    // synchronizer contents were discarded, so the pointer must re-propagate
    for (int k = 1; k <= 3; k++) begin
      e = '0; e.rempty = (k < 3); e.rlevel = (k < 3) ? 5'd0 : 5'd5;
      sbq.push_back(e);
    end
    for (int k = 1; k <= 3; k++) begin
      tick();
      e = sbq.pop_front();
      n_total++; if (rempty !== e.rempty) $display("FAIL mid_release_rempty edge=%0d got=%0b exp=%0b", k, rempty, e.rempty); else n_pass++;
      n_total++; if (rlevel !== e.rlevel) $display("FAIL mid_release_rlevel edge=%0d got=%0d exp=%0d", k, rlevel, e.rlevel); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_drain();
    test_underflow();
    test_single_word();
    test_wrap_full();
    test_reset_mid_drain();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
